// File: rtl/angle_pkg.sv
// rtl/angle_pkg.sv - shared constants, FSM encoding and width helper for the angle request scheduler
package angle_pkg;

   localparam int N_CH_MAX = 16;
   localparam int DATA_W   = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } sched_state_t;

   // Channel-ID width; never narrower than one bit so a single-channel build still elaborates.
   function automatic int CH_W(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/angle_tag_fifo.sv
// rtl/angle_tag_fifo.sv - first-word-fall-through FIFO holding the channel ID of each in-flight sample
module angle_tag_fifo #(
   parameter int DEPTH = 32,
   parameter int W     = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   // A pop in the same cycle frees the slot, so a full FIFO may still accept a push.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/angle_req_sched.sv
// rtl/angle_req_sched.sv - round-robin scheduler sharing one angle datapath among N_CH sample sources
module angle_req_sched
   import angle_pkg::CH_W;
   import angle_pkg::sched_state_t;
   import angle_pkg::S_IDLE;
   import angle_pkg::S_RUN;
   import angle_pkg::S_DRAIN;
#(
   parameter int N_CH      = 4,
   parameter int DATA_W    = angle_pkg::DATA_W,
   parameter int TAG_DEPTH = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic                      err_clr,
   input  logic [N_CH-1:0]           req_valid,
   output logic [N_CH-1:0]           req_ready,
   input  logic [N_CH*DATA_W-1:0]    req_real,
   input  logic [N_CH*DATA_W-1:0]    req_imag,
   output logic                      pipe_val,
   output logic [DATA_W-1:0]         pipe_real,
   output logic [DATA_W-1:0]         pipe_imag,
   input  logic                      pipe_res_val,
   input  logic [DATA_W-1:0]         pipe_res,
   output logic                      res_valid,
   output logic [$clog2(N_CH)-1:0]   res_ch,
   output logic [DATA_W-1:0]         res_data,
   output logic                      busy,
   output logic                      tag_err
);

   localparam int CW = CH_W(N_CH);
   localparam int TW = $clog2(TAG_DEPTH);

   sched_state_t     state;
   logic [CW-1:0]    rr_ptr;
   logic [N_CH-1:0]  prio_mask;
   logic [N_CH-1:0]  masked_req;
   logic [N_CH-1:0]  sel_req;
   logic [CW-1:0]    winner;
   logic             grant_en;
   logic             xfer;

   logic [CW-1:0]    head_tag;
   logic             fifo_full;
   logic             fifo_empty;
   logic [TW:0]      outstanding;

   // Channels at or above rr_ptr get first look; if none request, fall back to the full set (wrap).
   always_comb begin
      prio_mask = '0;
      for (int i = 0; i < N_CH; i++) prio_mask[i] = (i >= int'(rr_ptr));
      masked_req = req_valid & prio_mask;
      sel_req    = (|masked_req) ? masked_req : req_valid;
      winner     = '0;
      for (int i = N_CH-1; i >= 0; i--) begin
         if (sel_req[i]) winner = CW'(i);
      end
   end

   // A result arriving this cycle pops a tag, which leaves room for the new push even when full.
   assign grant_en = (state == S_RUN) && en && (!fifo_full || pipe_res_val);
   assign xfer     = grant_en && (|req_valid);

   always_comb begin
      req_ready = '0;
      if (xfer) req_ready[winner] = 1'b1;
   end

   assign busy = (state != S_IDLE);

   angle_tag_fifo #(
      .DEPTH (TAG_DEPTH),
      .W     (CW)
   ) u_tag_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (xfer),
      .din   (winner),
      .pop   (pipe_res_val),
      .dout  (head_tag),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (outstanding)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (en) state <= S_RUN;
            S_RUN:   if (!en) state <= S_DRAIN;
            S_DRAIN: begin
               if (en)                     state <= S_RUN;
               else if (outstanding == '0) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr    <= '0;
         pipe_val  <= 1'b0;
         pipe_real <= '0;
         pipe_imag <= '0;
      end else begin
         pipe_val <= xfer;
         if (xfer) begin
            rr_ptr    <= (winner == CW'(N_CH-1)) ? '0 : winner + CW'(1);
            pipe_real <= req_real[winner*DATA_W +: DATA_W];
            pipe_imag <= req_imag[winner*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_ch    <= '0;
         res_data  <= '0;
         tag_err   <= 1'b0;
      end else begin
         res_valid <= pipe_res_val && !fifo_empty;
         if (pipe_res_val && !fifo_empty) begin
            res_ch   <= head_tag;
            res_data <= pipe_res;
         end
         // A fresh orphan result outranks a clear in the same cycle.
         if (pipe_res_val && fifo_empty) tag_err <= 1'b1;
         else if (err_clr)               tag_err <= 1'b0;
      end
   end

endmodule
